// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches the word at decode's PC over a req/ack bus and holds it until consumed.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned PCs fault immediately without a bus request.

module fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOOP_WORD      = 32'h0000_0013
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_EN,
    input  logic [31:0] i_PC,
    output logic        o_IBUS_REQ,
    output logic [31:0] o_IBUS_ADDR,
    input  logic        i_IBUS_ACK,
    input  logic [31:0] i_IBUS_DATA,
    input  logic        i_IBUS_ERR,
    output logic        o_INSTRUCTION_VALID,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_FETCH_FAULT
);

    localparam int unsigned     CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [31:0]   instr_q, instr_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
                // addr_q still records the PC so a later redirect is detected in FAULT
                if (i_PC[1:0] != 2'b00) begin
                    addr_d  = i_PC;
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    instr_d = NOOP_WORD;
                    state_d = FAULT;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = i_PC;
                    cnt_d   = '0;
                    state_d = REQ;
                end
`else
                req_d   = 1'b1;
                addr_d  = i_PC;
                cnt_d   = '0;
                state_d = REQ;
`endif
            end
            REQ: begin
                if (i_IBUS_ACK) begin
                    if (i_IBUS_ERR) begin
                        req_d   = 1'b0;
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                        instr_d = NOOP_WORD;
                        state_d = FAULT;
                    end else if (i_PC == addr_q) begin
                        req_d   = 1'b0;
                        valid_d = 1'b1;
                        instr_d = i_IBUS_DATA;
                        state_d = HOLD;
                    end else begin
                        addr_d = i_PC;
                        cnt_d  = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    instr_d = NOOP_WORD;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD, FAULT: begin
                // A PC change with no consume strobe is a forced redirect
                if (i_EN || (i_PC != addr_q)) begin
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    instr_d = NOOP_WORD;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= NOOP_WORD;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_IBUS_REQ          = req_q;
    assign o_IBUS_ADDR         = addr_q;
    assign o_INSTRUCTION_VALID = valid_q;
    assign o_INSTRUCTION       = instr_q;
    assign o_FETCH_FAULT       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver acts as bus slave and decode, monitor checks each presented word.

module tb_fetch_unit;

    localparam int unsigned TO   = 16;
    localparam logic [31:0] NOOP = 32'h0000_0013;

    localparam int unsigned K_OK    = 0;
    localparam int unsigned K_STALE = 1;
    localparam int unsigned K_ERR   = 2;
    localparam int unsigned K_TO    = 3;
    localparam int unsigned K_UNAL  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pc = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [31:0] data = '0;
    logic        o_req, o_valid, o_fault;
    logic [31:0] o_addr, o_instr;

    fetch_unit #(.TIMEOUT_CYCLES(TO), .NOOP_WORD(NOOP)) dut (
        .i_CLK(clk), .i_RSTn(rst_n), .i_EN(en), .i_PC(pc),
        .o_IBUS_REQ(o_req), .o_IBUS_ADDR(o_addr),
        .i_IBUS_ACK(ack), .i_IBUS_DATA(data), .i_IBUS_ERR(err),
        .o_INSTRUCTION_VALID(o_valid), .o_INSTRUCTION(o_instr), .o_FETCH_FAULT(o_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    function automatic exp_t mk(input logic [31:0] i, input logic f);
        exp_t e;
        e.instr = i;
        e.fault = f;
        return e;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        r[1:0] = 2'b00;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every rising edge of VALID must match the oldest queued expectation
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (o_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid: got instr %h fault %b, expected no word (t=%0t)",
                         o_instr, o_fault, $time);
            end else begin
                e = sb_q.pop_front();
                check("sb_instr", o_instr, e.instr);
                check("sb_fault", 32'(o_fault), 32'(e.fault));
            end
        end
        prev_v = o_valid;
    end

    task automatic do_txn(input logic [31:0] tpc_in, input int unsigned kind, input int unsigned waits,
                          input int unsigned exp_lat, input logic [31:0] d, input logic [31:0] alt_in,
                          input int unsigned cmode, input logic [31:0] nxt_in, output logic [31:0] npc);
        logic [31:0] tpc, alt, nxt, exp_instr, good;
        int unsigned lat, cnt, h;
        bit          ok;
        tpc = tpc_in;
        alt = alt_in;
        nxt = nxt_in;
        exp_instr = NOOP;
        lat = 0;
        ok  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (kind == K_UNAL) begin
            bit req_seen;
            req_seen = 1'b0;
            sb_q.push_back(mk(NOOP, 1'b1));
            while (!ok && lat < 8) begin
                @(negedge clk);
                en = 1'b0;
                lat++;
                if (lat == 1) check("idle_valid_clear", 32'(o_valid), 0);
                if (o_req) req_seen = 1'b1;
                ok = o_valid;
            end
            check("align_no_req", 32'(req_seen), 0);
            check("align_fault_latency", lat, exp_lat);
        end else begin
`else
        begin
`endif
            while (!ok && lat < 8) begin
                @(negedge clk);
                en = 1'b0;
                lat++;
                if (lat == 1) begin
                    check("idle_valid_clear", 32'(o_valid), 0);
                    check("idle_fault_clear", 32'(o_fault), 0);
                end
                ok = o_req;
            end
            check("req_latency", lat, exp_lat);
            check("req_addr", o_addr, tpc);
            case (kind)
                K_STALE: begin
                    if (alt == tpc) alt = alt ^ 32'h4;
                    repeat (waits) @(negedge clk);
                    pc = alt;
                    data = d;
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                    check("stale_no_valid", 32'(o_valid), 0);
                    check("reissue_req", 32'(o_req), 1);
                    check("reissue_addr", o_addr, alt);
                    tpc = alt;
                    good = $urandom;
                    repeat (waits) @(negedge clk);
                    data = good;
                    ack = 1'b1;
                    sb_q.push_back(mk(good, 1'b0));
                    exp_instr = good;
                    @(negedge clk);
                    ack = 1'b0;
                    check("valid_after_ack", 32'(o_valid), 1);
                end
                K_ERR: begin
                    repeat (waits) @(negedge clk);
                    data = $urandom;
                    ack = 1'b1;
                    err = 1'b1;
                    sb_q.push_back(mk(NOOP, 1'b1));
                    @(negedge clk);
                    ack = 1'b0;
                    err = 1'b0;
                    check("valid_after_err", 32'(o_valid), 1);
                end
                K_TO: begin
                    sb_q.push_back(mk(NOOP, 1'b1));
                    cnt = 1;
                    ok = 1'b1;
                    while (ok && cnt < TO + 4) begin
                        @(negedge clk);
                        if (o_req) cnt++;
                        else ok = 1'b0;
                    end
                    check("timeout_req_cycles", cnt, TO);
                    check("timeout_valid", 32'(o_valid), 1);
                    data = $urandom;
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                    check("late_ack_instr", o_instr, NOOP);
                    check("late_ack_fault", 32'(o_fault), 1);
                end
                default: begin
                    repeat (waits) @(negedge clk);
                    data = d;
                    ack = 1'b1;
                    sb_q.push_back(mk(d, 1'b0));
                    exp_instr = d;
                    @(negedge clk);
                    ack = 1'b0;
                    check("valid_after_ack", 32'(o_valid), 1);
                end
            endcase
        end
        h = $urandom_range(0, 3);
        repeat (h) begin
            @(negedge clk);
            check("hold_valid", 32'(o_valid), 1);
            check("hold_instr", o_instr, exp_instr);
        end
        if (cmode == 0) nxt = tpc;
        else if (nxt == tpc) nxt = nxt ^ 32'h4;
        npc = nxt;
        pc = nxt;
        en = (cmode != 2);
    endtask

    initial begin
        logic [31:0] npc;
        int unsigned kind;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(o_req), 0);
        check("rst_addr", o_addr, 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_instr", o_instr, NOOP);
        check("rst_fault", 32'(o_fault), 0);
        rst_n = 1'b1;

        do_txn(32'h0, K_OK, 1, 1, 32'h0050_0093, 32'h0, 1, 32'h4, npc);
        do_txn(npc, K_OK, 0, 2, $urandom, 32'h0, 1, 32'h8, npc);
        do_txn(npc, K_STALE, 1, 2, 32'hDEAD_BEEF, 32'h100, 1, 32'h200, npc);
        do_txn(npc, K_ERR, 0, 2, 32'h0, 32'h0, 0, 32'h0, npc);
        do_txn(npc, K_TO, 0, 2, 32'h0, 32'h0, 2, 32'h302, npc);
        do_txn(npc, K_UNAL, 0, 2, $urandom, 32'h0, 1, 32'h400, npc);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            kind = (kind <= 4 || kind == 9) ? K_OK : (kind <= 6) ? K_STALE : (kind == 7) ? K_ERR : K_TO;
            do_txn(npc, kind, $urandom_range(0, 4), 2, $urandom, rand_pc(),
                   $urandom_range(0, 2), rand_pc(), npc);
        end

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 32'(o_req), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(o_req), 0);
        check("async_rst_addr", o_addr, 0);
        check("async_rst_valid", 32'(o_valid), 0);
        check("async_rst_instr", o_instr, NOOP);
        ack = 1'b1;
        data = $urandom;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("post_rst_req", 32'(o_req), 1);
        check("post_rst_addr", o_addr, npc);
        check("post_rst_ack_ignored", 32'(o_valid), 0);
        ack = 1'b1;
        err = 1'b1;
        sb_q.push_back(mk(NOOP, 1'b1));
        @(negedge clk);
        ack = 1'b0;
        err = 1'b0;
        check("err_fault", 32'(o_fault), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fault_valid", 32'(o_valid), 0);
        check("async_rst_fault_flag", 32'(o_fault), 0);
        check("async_rst_fault_instr", o_instr, NOOP);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish by t=%0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of decode.
- Takes the decode-owned program counter (decode o_PC), fetches the 32-bit word over a req/ack instruction bus, and presents it to decode's i_INSTRUCTION / i_INSTRUCTION_VALID.
- Holds each word until decode consumes it. Discards stale responses.
- Converts bus errors and timeouts into a flagged NOOP so the trap logic can react.

Parameters:
- TIMEOUT_CYCLES, 16, number of cycles o_IBUS_REQ may stay unacknowledged before a fetch fault. Minimum 2.
- NOOP_WORD, 32'h0000_0013, word driven on o_INSTRUCTION whenever no valid fetched word is held (addi x0,x0,0).

Ports:
- i_CLK  in  1  core clock; all state on rising edge.
- i_RSTn  in  1  asynchronous active-low reset.
- i_EN  in  1  pipeline advance from core control. Consume strobe when o_INSTRUCTION_VALID=1.
- i_PC  in  32  current program counter from decode.
- o_IBUS_REQ  out  1  bus read request; registered.
- o_IBUS_ADDR  out  32  word address; registered; stable while o_IBUS_REQ=1.
- i_IBUS_ACK  in  1  single-cycle response strobe.
- i_IBUS_DATA  in  32  read data; valid when i_IBUS_ACK=1.
- i_IBUS_ERR  in  1  bus error; qualified by i_IBUS_ACK.
- o_INSTRUCTION_VALID  out  1  o_INSTRUCTION holds a word for the current i_PC.
- o_INSTRUCTION  out  32  fetched word, or NOOP_WORD.
- o_FETCH_FAULT  out  1  the presented word is a fault NOOP (bus error or timeout).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, o_IBUS_REQ=0, o_IBUS_ADDR=0.
  - o_INSTRUCTION_VALID=0, o_INSTRUCTION=NOOP_WORD, o_FETCH_FAULT=0.
  - timeout counter=0.
- FSM states: IDLE, REQ, HOLD, FAULT.
- IDLE:
  - Next edge: o_IBUS_REQ<=1, o_IBUS_ADDR<=i_PC, counter<=0, go to REQ.
  - IDLE lasts exactly one cycle after reset or consume.
- REQ:
  - o_IBUS_REQ stays 1 with the address held; counter increments each cycle.
  - Ack, no error, i_PC==o_IBUS_ADDR: latch i_IBUS_DATA into o_INSTRUCTION, VALID<=1, REQ<=0, go to HOLD.
  - Ack, no error, i_PC!=o_IBUS_ADDR (stale): drop the data, reissue to the new i_PC next edge, stay in REQ, counter<=0.
  - Ack with i_IBUS_ERR=1: o_INSTRUCTION<=NOOP_WORD, VALID<=1, FAULT<=1, REQ<=0, go to FAULT.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: same result as a bus error. A late ack arriving after that is ignored.
- HOLD / FAULT:
  - Outputs stay constant until consumed (i_EN=1).
  - On consume: VALID<=0, FAULT<=0, o_INSTRUCTION<=NOOP_WORD, go to IDLE.
  - i_PC change without i_EN (forced redirect): treated as consume.
- Latency:
  - New PC visible in IDLE at cycle N gives REQ high at N+1.
  - Ack at cycle M gives VALID high at M+1.
  - Zero-wait bus: one instruction every 3 cycles.
- Simultaneous events:
  - Consume and redirect in the same cycle: one return to IDLE.
  - i_EN=0 in REQ has no effect; the request continues.
- Reset mid-request: o_IBUS_REQ drops immediately (async). An outstanding ack after release is ignored because state is IDLE.
- Acks outside REQ are always ignored.
- Address width: full 32 bits passed through; no increment logic here (decode computes PC).

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, if i_PC[1:0]!=2'b00, no bus request is issued.
  - Go straight to FAULT next edge: VALID=1, FAULT=1, NOOP_WORD.
  - Aligned PCs behave as above.
- Undefined: no check; o_IBUS_ADDR<=i_PC unmodified. The bus handles low bits.

Test Plan:
- Reset release, i_PC=0, ack with DATA=32'h00500093 two cycles after REQ:
  - REQ high at cycle 1, ADDR=0.
  - VALID=1 with o_INSTRUCTION=32'h00500093 the cycle after ack.
  - Held while i_EN=0.
- Back-to-back: consume with i_EN=1, i_PC 0->4, zero-wait ack:
  - REQ with ADDR=4 one cycle after consume.
  - VALID again 3 cycles after the previous consume.
- Redirect during REQ: ADDR=8 outstanding, i_PC changes to 32'h100 before ack, ack DATA=32'hDEADBEEF:
  - Data dropped, VALID stays 0.
  - New REQ with ADDR=32'h100; VALID only after its ack.
- Bus error: ack with ERR=1:
  - VALID=1, FAULT=1, o_INSTRUCTION=32'h00000013.
  - On i_EN both clear and IDLE is entered.
- Timeout: no ack for 16 cycles:
  - FAULT=1 and VALID=1 at cycle 16 of REQ, REQ low.
  - An ack arriving at cycle 18 is ignored (o_INSTRUCTION stays NOOP).
- Async reset asserted in REQ mid-cycle: REQ, VALID and FAULT go 0 without a clock edge. With FETCH_ALIGN_CHECK_EN defined, i_PC=32'h2 gives FAULT with no REQ pulse.
